vbuffer_wctl: RTL and testbench

VBUFFER_WCTL -- requirements
Module: vbuffer_wctl

---
 rtl/vbuffer_pkg.sv | 35 +++
 rtl/rr_arb2.sv | 27 ++
 rtl/vbuffer_wctl.sv | 150 +++++++++++++++
 tb/tb_vbuffer_wctl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vbuffer_pkg.sv
// ---------------------------------------------------------------------------
// vbuffer_pkg
//   Shared definitions for the vbuffer write controller.
//   - VB_DATA_WIDTH : default vbuffer word width (18 bits x 3 x 4 = 216)
//   - VB_ADDR_WIDTH : default vbuffer address width (4096 words)
//   - wctl_state_t  : controller state (S_RUN arbitrates the requesters,
//                     S_CLEAR walks the whole vbuffer writing zeros)
//   - next_grant()  : rotated priority helper used by the arbiter
// ---------------------------------------------------------------------------
package vbuffer_pkg;

  localparam int VB_DATA_WIDTH = 216;
  localparam int VB_ADDR_WIDTH = 12;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } wctl_state_t;

  // Two-way round-robin rule. last_grant is the index of the requester that
  // won the previous accepted transfer; under contention the other one wins.
  function automatic logic [1:0] next_grant(input logic [1:0] req,
                                            input logic       last_grant);
    logic [1:0] grant;
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage : vbuffer_pkg

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Purely combinational two-way round-robin arbiter.
//   Ports:
//     req[1:0]    in  : request vector, bit i = requester i has a write pending
//     last_grant  in  : index of the requester granted on the last accepted
//                       transfer (1 after reset so requester 0 wins first)
//     grant[1:0]  out : one-hot (or zero) grant, only toward a requesting bit
//   The caller decides whether the grant is actually usable (state, clear,
//   reset); this block only expresses the fairness rule.
// ---------------------------------------------------------------------------
module rr_arb2
  import vbuffer_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    grant = 2'b00;
    grant = next_grant(req, last_grant);
  end

endmodule : rr_arb2

// File: rtl/vbuffer_wctl.sv
// ---------------------------------------------------------------------------
// vbuffer_wctl
//   Write-port controller for the vbuffer RAM (the RAM itself lives in the
//   parent). Two requesters share the single write port through a
//   round-robin arbiter; a clear request zero-fills every address.
//
//   Parameters:
//     DATA_WIDTH : vbuffer word width
//     ADDR_WIDTH : vbuffer address width (2**ADDR_WIDTH words)
//
//   Ports:
//     clock                in  : single clock, also the vbuffer write_clock
//     reset                in  : asynchronous, active-high reset
//     req0_valid/req1_valid in : requester has a write pending
//     req0_addr/req1_addr  in  : requester write address
//     req0_data/req1_data  in  : requester write data
//     req0_ready/req1_ready out: combinational; write taken when valid&&ready
//     clear_req            in  : single-cycle pulse, zero-fill the vbuffer
//     clear_busy           out : registered, high while clear writes are on vb_*
//     clear_done           out : registered, one-cycle pulse after last clear write
//     vb_we/vb_addr/vb_data out: registered vbuffer write port
//
//   Timing: a transfer accepted in cycle N appears on vb_* in cycle N+1.
//   A clear_req in cycle N puts address 0 on vb_* in cycle N+1, then one
//   address per cycle up to all-ones; clear_done and the return to S_RUN
//   happen together in the cycle after the last clear write, so requesters
//   may already be accepted in the clear_done cycle.
// ---------------------------------------------------------------------------
module vbuffer_wctl
  import vbuffer_pkg::*;
#(
  parameter int DATA_WIDTH = VB_DATA_WIDTH,
  parameter int ADDR_WIDTH = VB_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,

  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,

  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,

  output logic                  vb_we,
  output logic [ADDR_WIDTH-1:0] vb_addr,
  output logic [DATA_WIDTH-1:0] vb_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  wctl_state_t           state;
  logic [ADDR_WIDTH-1:0] clear_count;  // address currently presented by the clear walk
  logic                  last_grant;   // requester index of the last accepted transfer
  logic [1:0]            grant;
  logic                  run_open;

  // -------------------------------------------------------------------------
  // Arbitration. The arbiter only sees the valids; the gating below keeps
  // ready low during reset, during a clear, and in the cycle a clear is
  // requested so clear always wins over a simultaneous write.
  // -------------------------------------------------------------------------
  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign run_open   = !reset && (state == S_RUN) && !clear_req;
  assign req0_ready = run_open && grant[0];
  assign req1_ready = run_open && grant[1];

  // -------------------------------------------------------------------------
  // Control FSM and registered write port.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      clear_count <= '0;
      last_grant  <= 1'b1;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      vb_we       <= 1'b0;
      vb_addr     <= '0;
      vb_data     <= '0;
    end else begin
      case (state)
        S_RUN: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            // First clear write is issued straight away so the walk is
            // exactly 2**ADDR_WIDTH consecutive cycles of clear_busy.
            state       <= S_CLEAR;
            clear_busy  <= 1'b1;
            clear_count <= '0;
            vb_we       <= 1'b1;
            vb_addr     <= '0;
            vb_data     <= '0;
          end else if (req0_ready) begin
            vb_we      <= 1'b1;
            vb_addr    <= req0_addr;
            vb_data    <= req0_data;
            last_grant <= 1'b0;
          end else if (req1_ready) begin
            vb_we      <= 1'b1;
            vb_addr    <= req1_addr;
            vb_data    <= req1_data;
            last_grant <= 1'b1;
          end else begin
            // Idle: address/data keep their last values.
            vb_we <= 1'b0;
          end
        end

        S_CLEAR: begin
          // clear_req is deliberately not examined here: a request during
          // a clear neither restarts nor queues another one.
          if (clear_count == LAST_ADDR) begin
            clear_count <= '0;
            state       <= S_RUN;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b1;
            vb_we       <= 1'b0;
          end else begin
            clear_count <= clear_count + ADDR_ONE;
            vb_we       <= 1'b1;
            vb_addr     <= clear_count + ADDR_ONE;
            vb_data     <= '0;
          end
        end

        default: begin
          state <= S_RUN;
          vb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule : vbuffer_wctl

// File: tb/tb_vbuffer_wctl.sv
module tb_vbuffer_wctl;

  localparam int DW    = 216;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          clear_req, clear_busy, clear_done;
  logic          vb_we;
  logic [AW-1:0] vb_addr;
  logic [DW-1:0] vb_data;

  vbuffer_wctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .vb_we      (vb_we),
    .vb_addr    (vb_addr),
    .vb_data    (vb_data)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard: writes the vbuffer must see, in order.
  wr_t exp_q[$];

  // Reference model state.
  int  clr_left;   // clear writes still to appear on vb_*
  bit  done_pend;  // clear_done expected this cycle
  bit  acc_prev;   // a requester write was accepted last cycle
  int  m_last;     // requester that won the last accepted transfer
  wr_t hold_val;   // vb_addr/vb_data expected while vb_we is low
  bit  acc0, acc1; // model acceptance in the cycle just evaluated

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [DW-1:0] act,
                           input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) r = {r[DW-33:0], $urandom()};
    return r;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    clr_left  = 0;
    done_pend = 0;
    acc_prev  = 0;
    m_last    = 1;
    hold_val  = '0;
    acc0      = 0;
    acc1      = 0;
  endfunction

  // One clock cycle. Called 1 time unit after a rising edge with the inputs
  // for this cycle already driven; evaluates the model mid-cycle, compares
  // the registered status and the combinational readies, then advances to
  // 1 time unit after the next rising edge.
  task automatic step();
    bit busy, r0, r1, start_clr;
    #3;
    busy      = (clr_left > 0);
    r0        = 0;
    r1        = 0;
    start_clr = 0;
    if (reset) begin
      check_bit("rst_vb_we", vb_we, 1'b0);
      check_bit("rst_clear_busy", clear_busy, 1'b0);
      check_bit("rst_clear_done", clear_done, 1'b0);
      check_vec("rst_vb_addr", DW'(vb_addr), '0);
      check_vec("rst_vb_data", vb_data, '0);
      model_reset();
    end else begin
      check_bit("clear_busy", clear_busy, busy);
      check_bit("clear_done", clear_done, done_pend);
      check_bit("vb_we", vb_we, busy || acc_prev);
      if (!busy) begin
        if (clear_req)                                    start_clr = 1;
        else if (req0_valid && (!req1_valid || m_last == 1)) r0 = 1;
        else if (req1_valid)                              r1 = 1;
      end
      done_pend = (clr_left == 1);
      if (clr_left > 0) clr_left--;
      if (start_clr) begin
        clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{addr: AW'(i), data: '0});
      end
      if (r0) begin
        exp_q.push_back('{addr: req0_addr, data: req0_data});
        m_last = 0;
      end
      if (r1) begin
        exp_q.push_back('{addr: req1_addr, data: req1_data});
        m_last = 1;
      end
      acc_prev = r0 || r1;
    end
    check_bit("req0_ready", req0_ready, r0);
    check_bit("req1_ready", req1_ready, r1);
    acc0 = r0;
    acc1 = r1;
    @(posedge clock);
    #1;
  endtask

  // Requesters keep addr/data stable until accepted, then maybe raise a new one.
  task automatic drive_reqs(input int pct);
    if (acc0 || !req0_valid) begin
      req0_valid = ($urandom_range(99) < pct);
      req0_addr  = AW'($urandom_range(DEPTH - 1));
      req0_data  = rnd_data();
    end
    if (acc1 || !req1_valid) begin
      req1_valid = ($urandom_range(99) < pct);
      req1_addr  = AW'($urandom_range(DEPTH - 1));
      req1_data  = rnd_data();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (vb_we) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h with empty scoreboard at %0t",
                     vb_addr, $time);
          end else begin
            e = exp_q.pop_front();
            check_vec("vb_addr", DW'(vb_addr), DW'(e.addr));
            check_vec("vb_data", vb_data, e.data);
            hold_val = e;
          end
        end else begin
          check_vec("vb_addr_hold", DW'(vb_addr), DW'(hold_val.addr));
          check_vec("vb_data_hold", vb_data, hold_val.data);
        end
      end
    end
  end

  initial begin
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    clear_req  = 1'b0;
    model_reset();
    @(posedge clock);
    #1;

    // Readies stay low while reset is high even with a valid pending.
    req0_valid = 1'b1;
    apply_reset();
    req0_valid = 1'b0;
    step();

    // Single requester: accepted same cycle, written the next.
    req0_valid = 1'b1; req0_addr = AW'(5); req0_data = {27{8'hA5}};
    step();
    req0_valid = 1'b0;
    step();
    step();

    // Both requesters valid continuously from reset: grants alternate 0,1,0,1.
    apply_reset();
    req0_valid = 1'b1; req0_addr = AW'(1); req0_data = rnd_data();
    req1_valid = 1'b1; req1_addr = AW'(2); req1_data = rnd_data();
    for (int k = 0; k < 4; k++) begin
      step();
      if (acc0) begin req0_addr = req0_addr + AW'(2); req0_data = rnd_data(); end
      if (acc1) begin req1_addr = req1_addr + AW'(2); req1_data = rnd_data(); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    // Clear with a simultaneous req1: req1 waits out the clear.
    req1_valid = 1'b1; req1_addr = AW'(9); req1_data = {27{8'h3C}};
    clear_req  = 1'b1;
    step();
    clear_req  = 1'b0;
    repeat (DEPTH) step();
    step();
    req1_valid = 1'b0;
    step();
    step();

    // Second clear_req at counter 7 is ignored.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (7) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (DEPTH) step();

    // Reset at counter 9 aborts the clear immediately.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    req0_valid = 1'b1; req0_addr = AW'(3); req0_data = rnd_data();
    #1;
    reset = 1'b1;
    #1;
    check_bit("async_rst_vb_we", vb_we, 1'b0);
    check_bit("async_rst_clear_busy", clear_busy, 1'b0);
    check_bit("async_rst_req0_ready", req0_ready, 1'b0);
    model_reset();
    @(posedge clock);
    #1;
    step();
    reset = 1'b0;
    step();
    req0_valid = 1'b0;
    repeat (3) step();

    // Randomized traffic with occasional clear requests (some during clears).
    for (int n = 0; n < 1500; n++) begin
      drive_reqs(60);
      clear_req = ($urandom_range(99) < 2);
      step();
    end
    clear_req  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (DEPTH + 4) step();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d writes never seen, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_vbuffer_wctl
